pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the IF stage, successor to the fixed 32-bit PC register. Produces the fetch address and memory enable, steps by a configurable instruction size, and accepts exception redirects from ctrl and branch redirects from ID. It adds a fetch-ready handshake with instruction memory and a one-entry pending-redirect register, so a branch that arrives while fetch is held is not lost. Optionally, it checks redirect-target alignment.

## Interface
Parameters:
- ADDR_W, 32, PC/address width.
- INST_BYTES, 4, PC increment; power of two, 1..8.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset (ADDR_W bits).
- STALL_W, 6, width of the ctrl stall bus; only bit 0 is used.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  STALL_W  ctrl stall bus; stall[0]=1 holds PC.
- flush  in  1  pipeline flush from ctrl.
- new_pc  in  ADDR_W  exception handler entry address, valid with flush.
- branch_flag_i  in  1  ID reports a taken branch/jump.
- branch_target_address_i  in  ADDR_W  branch target, valid with branch_flag_i.
- if_ready_i  in  1  instruction memory accepts the current request.
- pc  out  ADDR_W  fetch address.
- ce  out  1  instruction memory enable / request valid.
- redirect_pending_o  out  1  a branch target is held in the pending register.
- misalign_o  out  1  one-cycle pulse when a misaligned redirect was loaded; constant 0 without PC_ALIGN_CHECK_EN.

## Operation
- States:
  - OFF: entered on reset; ce=0.
  - RUN: entered the first clock after reset deassertion and held until the next reset.
- Advance condition: adv = ce & ~stall[0] & if_ready_i.
- In RUN, the next pc is chosen by the first matching priority:
  1. flush=1: pc<=new_pc; clear pending. This ignores stall and if_ready_i.
  2. adv & branch_flag_i: pc<=branch_target_address_i; clear pending.
  3. adv & pend_valid: pc<=pend_addr; clear pending.
  4. adv: pc<=pc+INST_BYTES, truncated to ADDR_W. Wrap-around is modulo 2^ADDR_W (e.g. 32'hFFFF_FFFC -> 0).
  5. Otherwise: pc is held.
- Pending capture: when branch_flag_i=1, flush=0 and adv=0, pend_addr<=branch_target_address_i and pend_valid<=1. A later branch overwrites an earlier pending target.
- The pending register is internal; redirect_pending_o = pend_valid.
- In OFF, pc stays at RESET_VECTOR.

## Timing
- Reset values: pc=RESET_VECTOR, ce=0, redirect_pending_o=0, misalign_o=0, pend_addr=0, state=OFF.
- Cycle 1 after rst rises: ce=1 and pc=RESET_VECTOR. This is the first request.
- Latency: every redirect appears on pc at the next rising edge (1 cycle). The pending register adds no extra cycle beyond the one in which adv becomes 1.
- ce is held at 1 and pc held stable while if_ready_i=0. Instruction memory samples pc when ce & if_ready_i.
- Simultaneous events:
  - flush with branch: flush wins and the branch is dropped.
  - flush with pending: pending is cleared.
  - branch with pending and adv: the live branch wins.
- An asynchronous rst assertion mid-stall or mid-pending immediately forces all reset values.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - Any loaded redirect target (new_pc, branch target, or pending) with nonzero low log2(INST_BYTES) bits is loaded with those bits cleared.
  - misalign_o pulses 1 for exactly the cycle in which pc shows that target.
  - For INST_BYTES=1 the check is inert.
- PC_ALIGN_CHECK_EN undefined: targets are loaded verbatim and misalign_o is tied to 0.

## Test plan
- Reset and run, ADDR_W=32, INST_BYTES=4, RESET_VECTOR=32'hBFC0_0000, if_ready_i=1: release rst -> ce=1 with pc=BFC0_0000, then BFC0_0004 and BFC0_0008 on successive cycles.
- Stall and backpressure: stall[0]=1 for 3 cycles, then if_ready_i=0 for 2 cycles -> pc constant and ce=1 throughout; increment resumes on the first cycle both conditions clear.
- Branch during stall: stall[0]=1 and branch_flag_i=1 for one cycle with target 0x100 -> redirect_pending_o=1. After the stall releases, pc=0x100 at the next edge, pending clears, and the following address is 0x104.
- Flush priority: flush=1 with new_pc=0x180, branch_flag_i=1 with target 0x200, pending set, stall[0]=1 -> pc=0x180 next cycle and redirect_pending_o=0.
- Wrap and align: pc=FFFF_FFFC advancing -> pc=0. With PC_ALIGN_CHECK_EN, branch to 0x102 -> pc=0x100 and misalign_o=1 for one cycle. Without the macro -> pc=0x102 and misalign_o=0.
- Async reset mid-pending: assert rst while redirect_pending_o=1 and stall[0]=1 -> pc=RESET_VECTOR and ce=0 without waiting for a clock edge; pending is lost.

Source files
------------

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Purpose  : Program-counter generator for the instruction-fetch stage.
//             Steps the fetch address by INST_BYTES whenever instruction
//             memory accepts a request. Takes flush redirects from ctrl and
//             branch redirects from ID. A one-entry pending register holds
//             a branch target that arrives while fetch is not advancing.
//  Ports    : clk                     - system clock, rising edge
//             rst                     - asynchronous reset, active low
//             stall[STALL_W-1:0]      - ctrl stall bus, bit 0 holds the PC
//             flush / new_pc          - exception redirect
//             branch_flag_i / branch_target_address_i - ID branch redirect
//             if_ready_i              - instruction memory accepts request
//             pc / ce                 - fetch address / request valid
//             redirect_pending_o      - a branch target is held pending
//             misalign_o              - misaligned redirect loaded (pulse)
//  Options  : PC_ALIGN_CHECK_EN - when defined, loaded redirect targets are
//             forced to INST_BYTES alignment and misalign_o pulses. When
//             undefined, targets load verbatim and misalign_o stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int                ADDR_W       = 32,
    parameter int                INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               if_ready_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending_o,
    output logic               misalign_o
);

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_BYTES);

`ifdef PC_ALIGN_CHECK_EN
    // Low address bits that must be zero for an aligned target. This is
    // all-zero for INST_BYTES=1, which makes the check inert.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
`else
    localparam logic [ADDR_W-1:0] ALIGN_MASK = '0;
`endif

    typedef enum logic [0:0] {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_valid_q, pend_valid_d;
    logic              misalign_q, misalign_d;

    logic              adv;
    logic [ADDR_W-1:0] target;
    logic              load_target;

    // Only bit 0 of the stall bus is meaningful here.
    logic unused_stall;
    assign unused_stall = |stall;

    assign ce  = (state_q == ST_RUN);
    assign adv = ce & ~stall[0] & if_ready_i;

    // Redirect source selection, in priority order. The pending target is
    // only used when no live redirect is present.
    always_comb begin
        target      = pc_q;
        load_target = 1'b0;
        if (flush) begin
            target      = new_pc;
            load_target = 1'b1;
        end else if (adv && branch_flag_i) begin
            target      = branch_target_address_i;
            load_target = 1'b1;
        end else if (adv && pend_valid_q) begin
            target      = pend_addr_q;
            load_target = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_addr_d  = pend_addr_q;
        pend_valid_d = pend_valid_q;
        misalign_d   = 1'b0;

        case (state_q)
            ST_OFF: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (load_target) begin
                    pc_d         = target & ~ALIGN_MASK;
                    misalign_d   = |(target & ALIGN_MASK);
                    pend_valid_d = 1'b0;
                end else if (adv) begin
                    pc_d = pc_q + PC_INC;
                end

                // Branch seen while fetch is held: park it. A newer branch
                // simply overwrites an older parked one.
                if (branch_flag_i && !flush && !adv) begin
                    pend_addr_d  = branch_target_address_i;
                    pend_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_OFF;
            pc_q         <= RESET_VECTOR;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc                 = pc_q;
    assign redirect_pending_o = pend_valid_q;
    assign misalign_o         = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_gen
//  Purpose  : Directed self-checking bench for pc_gen (ADDR_W=32,
//             INST_BYTES=4, RESET_VECTOR=BFC0_0000). Expected values in the
//             alignment section depend on PC_ALIGN_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        if_ready;
    logic [31:0] pc;
    logic        ce;
    logic        pending;
    logic        misalign;

    int n_total = 0;
    int n_bad   = 0;

    pc_gen #(
        .ADDR_W       (32),
        .INST_BYTES   (4),
        .RESET_VECTOR (RV),
        .STALL_W      (6)
    ) u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag),
        .branch_target_address_i (branch_target),
        .if_ready_i              (if_ready),
        .pc                      (pc),
        .ce                      (ce),
        .redirect_pending_o      (pending),
        .misalign_o              (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b0;
        stall         = '0;
        flush         = 1'b0;
        new_pc        = '0;
        branch_flag   = 1'b0;
        branch_target = '0;
        if_ready      = 1'b1;

        // Reset state
        step(); step();
        check("rst_pc",   pc, RV);
        check("rst_ce",   {31'd0, ce}, 32'd0);
        check("rst_pend", {31'd0, pending}, 32'd0);
        check("rst_mis",  {31'd0, misalign}, 32'd0);

        // Release reset and run sequentially
        rst = 1'b1;
        step();
        check("run0_ce", {31'd0, ce}, 32'd1);
        check("run0_pc", pc, RV);
        step();
        check("run1_pc", pc, 32'hBFC0_0004);
        step();
        check("run2_pc", pc, 32'hBFC0_0008);

        // Stall for three cycles, then backpressure for two
        stall = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'hBFC0_0008);
            check("stall_ce", {31'd0, ce}, 32'd1);
        end
        stall    = '0;
        if_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_pc", pc, 32'hBFC0_0008);
            check("bp_ce", {31'd0, ce}, 32'd1);
        end
        if_ready = 1'b1;
        step();
        check("resume_pc", pc, 32'hBFC0_000C);

        // Branch during stall is parked, then taken on release
        stall         = 6'b000001;
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0100;
        step();
        check("bstall_pc",   pc, 32'hBFC0_000C);
        check("bstall_pend", {31'd0, pending}, 32'd1);
        branch_flag = 1'b0;
        step();
        check("bhold_pend", {31'd0, pending}, 32'd1);
        stall = '0;
        step();
        check("btake_pc",   pc, 32'h0000_0100);
        check("btake_pend", {31'd0, pending}, 32'd0);
        step();
        check("bnext_pc", pc, 32'h0000_0104);

        // Flush beats live branch and pending, ignores stall
        stall         = 6'b000001;
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0200;
        step();
        check("fpre_pend", {31'd0, pending}, 32'd1);
        flush  = 1'b1;
        new_pc = 32'h0000_0180;
        step();
        check("flush_pc",   pc, 32'h0000_0180);
        check("flush_pend", {31'd0, pending}, 32'd0);
        flush       = 1'b0;
        branch_flag = 1'b0;
        stall       = '0;

        // Live branch wins over pending when advancing
        stall         = 6'b000001;
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0300;
        step();
        stall         = '0;
        branch_target = 32'h0000_0400;
        step();
        check("live_pc",   pc, 32'h0000_0400);
        check("live_pend", {31'd0, pending}, 32'd0);
        branch_flag = 1'b0;

        // Wrap-around
        flush  = 1'b1;
        new_pc = 32'hFFFF_FFFC;
        step();
        check("wpre_pc", pc, 32'hFFFF_FFFC);
        flush = 1'b0;
        step();
        check("wrap_pc", pc, 32'h0000_0000);

        // Misaligned branch target
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0102;
        step();
        branch_flag = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        check("mis_pc",  pc, 32'h0000_0100);
        check("mis_flg", {31'd0, misalign}, 32'd1);
        step();
        check("mis_next_pc", pc, 32'h0000_0104);
`else
        check("mis_pc",  pc, 32'h0000_0102);
        check("mis_flg", {31'd0, misalign}, 32'd0);
        step();
        check("mis_next_pc", pc, 32'h0000_0106);
`endif
        check("mis_clr", {31'd0, misalign}, 32'd0);

        // Asynchronous reset while stalled with a parked branch
        stall         = 6'b000001;
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0500;
        step();
        check("apre_pend", {31'd0, pending}, 32'd1);
        branch_flag = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_pc",   pc, RV);
        check("async_ce",   {31'd0, ce}, 32'd0);
        check("async_pend", {31'd0, pending}, 32'd0);
        step();
        rst   = 1'b1;
        stall = '0;
        step();
        check("rerun_ce",   {31'd0, ce}, 32'd1);
        check("rerun_pc",   pc, RV);
        check("rerun_pend", {31'd0, pending}, 32'd0);
        step();
        check("rerun1_pc", pc, 32'hBFC0_0004);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
